// File: rtl/debounce_en_gen.sv
// debounce_en_gen: synchronises and debounces a bouncy asynchronous input.
// Outputs are a clean level (d_out) and one-cycle strobes (en_pulse, rise,
// fall) on every accepted change. busy is high while a change is in progress.
// Optional macro DEBOUNCE_LOCKOUT_EN adds a hold-off (LOCK) state after each
// accepted change. While in LOCK the synchronised input is ignored.
module debounce_en_gen #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CNT     = 8,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic d_out,
  output logic en_pulse,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CNT) + 1;

  // Catch illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_en_gen: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("debounce_en_gen: STABLE_CNT must be >= 2");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lock
    $error("debounce_en_gen: LOCKOUT_CYCLES must be >= 1");
  end

`ifdef DEBOUNCE_LOCKOUT_EN
  typedef enum logic [1:0] {IDLE, COUNT, LOCK} state_t;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  logic [LW-1:0] lcnt;
`else
  typedef enum logic {IDLE, COUNT} state_t;
`endif

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_out;

  assign sync_out = sync_pipe[SYNC_STAGES-1];

  // Synchroniser chain: raw_in enters at bit 0, sync_out is the last stage.
  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw_in};
  end

  // Debounce FSM. All outputs are registered. busy tracks the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      d_out    <= 1'b0;
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
`ifdef DEBOUNCE_LOCKOUT_EN
      lcnt     <= '0;
`endif
    end else begin
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_out != d_out) begin
            state <= COUNT;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        COUNT: begin
          if (sync_out == d_out) begin
            // Bounced back before being accepted: drop the attempt silently.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CW'(STABLE_CNT - 1)) begin
            d_out    <= sync_out;
            en_pulse <= 1'b1;
            rise     <= sync_out;
            fall     <= ~sync_out;
            cnt      <= '0;
`ifdef DEBOUNCE_LOCKOUT_EN
            state    <= LOCK;
            lcnt     <= '0;
            busy     <= 1'b1;
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
          end else begin
            cnt  <= cnt + CW'(1);
            busy <= 1'b1;
          end
        end
`ifdef DEBOUNCE_LOCKOUT_EN
        LOCK: begin
          // Hold off for LOCKOUT_CYCLES cycles. The input is ignored here.
          if (lcnt == LW'(LOCKOUT_CYCLES - 1)) begin
            state <= IDLE;
            lcnt  <= '0;
            busy  <= 1'b0;
          end else begin
            lcnt  <= lcnt + LW'(1);
            busy  <= 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_en_gen.sv
// Directed, table-driven bench for debounce_en_gen (SYNC_STAGES=2,
// STABLE_CNT=4). Expected output vector per row is {d_out,en_pulse,rise,fall,busy}.
module tb_debounce_en_gen;

  logic clk = 1'b0;
  logic reset, raw_in;
  logic d_out, en_pulse, rise, fall, busy;

`ifdef DEBOUNCE_LOCKOUT_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  debounce_en_gen #(.SYNC_STAGES(2), .STABLE_CNT(4), .LOCKOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .d_out(d_out),
    .en_pulse(en_pulse), .rise(rise), .fall(fall), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       raw;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   errs = 0;
  int   checks = 0;

  function automatic logic [4:0] outs();
    return {d_out, en_pulse, rise, fall, busy};
  endfunction

  task automatic add(input logic rs, input logic rw, input logic d,
                     input logic en, input logic r, input logic f, input logic b);
    vec_t v;
    v.rst = rs; v.raw = rw; v.exp = {d, en, r, f, b};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got {d,en,r,f,busy}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fall_edge;
    reset  = 1'b1;
    raw_in = 1'b1;

    // Reset with raw_in high: nothing may propagate.
    add(1,1, 0,0,0,0,0); add(1,1, 0,0,0,0,0);
    add(0,0, 0,0,0,0,0); add(0,0, 0,0,0,0,0);
    // Clean rise: accepted 5 edges after the first sample.
    add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,1);
    add(0,1, 0,0,0,0,1); add(0,1, 0,0,0,0,1); add(0,1, 1,1,1,0,LK);
    add(0,1, 1,0,0,0,LK); add(0,1, 1,0,0,0,LK); add(0,1, 1,0,0,0,LK);
    add(0,1, 1,0,0,0,0);
    // Two-cycle glitch low: counted then dropped.
    add(0,0, 1,0,0,0,0); add(0,0, 1,0,0,0,0); add(0,1, 1,0,0,0,1);
    add(0,1, 1,0,0,0,1); add(0,1, 1,0,0,0,0); add(0,1, 1,0,0,0,0);
    // Three-cycle glitch (STABLE_CNT-1 samples): still rejected.
    add(0,0, 1,0,0,0,0); add(0,0, 1,0,0,0,0); add(0,0, 1,0,0,0,1);
    add(0,1, 1,0,0,0,1); add(0,1, 1,0,0,0,1); add(0,1, 1,0,0,0,0);
    add(0,1, 1,0,0,0,0);
    // Clean fall.
    add(0,0, 1,0,0,0,0); add(0,0, 1,0,0,0,0); add(0,0, 1,0,0,0,1);
    add(0,0, 1,0,0,0,1); add(0,0, 1,0,0,0,1); add(0,0, 0,1,0,1,LK);
    add(0,0, 0,0,0,0,LK); add(0,0, 0,0,0,0,LK); add(0,0, 0,0,0,0,LK);
    add(0,0, 0,0,0,0,0);
`ifndef DEBOUNCE_LOCKOUT_EN
    // Back-to-back: a 4-wide pulse is accepted and the return to 0 starts
    // counting on the very next edge, giving strobes STABLE_CNT apart.
    add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,0); add(0,1, 0,0,0,0,1);
    add(0,1, 0,0,0,0,1); add(0,0, 0,0,0,0,1); add(0,0, 1,1,1,0,0);
    add(0,0, 1,0,0,0,1); add(0,0, 1,0,0,0,1); add(0,0, 1,0,0,0,1);
    add(0,0, 0,1,0,1,0); add(0,0, 0,0,0,0,0); add(0,0, 0,0,0,0,0);
`endif

    foreach (tbl[i]) begin
      reset  = tbl[i].rst;
      raw_in = tbl[i].raw;
      tick();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Reset in the middle of a count: change is discarded, no strobe later.
    reset = 1'b0; raw_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("midcnt_busy", outs(), 5'b00001);
    reset = 1'b1; raw_in = 1'b0;
    tick();
    check("midcnt_reset", outs(), 5'b00000);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("midcnt_after%0d", k), outs(), 5'b00000);
    end

`ifdef DEBOUNCE_LOCKOUT_EN
    // Lockout: rise at edge 5, raw back to 0 for edge 6; fall must wait
    // for LOCK (edges 5..8) plus a fresh count, landing on edge 13.
    raw_in = 1'b1;
    fall_edge = -1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (e == 5) begin
        check("lock_rise", outs(), 5'b11101);
        raw_in = 1'b0;
      end
      if (e >= 6 && e <= 8) check($sformatf("lock_busy%0d", e), {4'b0, busy}, 5'b00001);
      if (e == 9) check("lock_exit", {4'b0, busy}, 5'b00000);
      if (e > 5 && en_pulse && fall_edge < 0) fall_edge = e;
    end
    check_int("lock_fall_edge", fall_edge, 13);
`else
    fall_edge = 0;
    check_int("nolock_placeholder_edge", fall_edge + int'(d_out), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
